// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: single-approach RED/GREEN/YELLOW signal head with optional yellow expiry and flash mode (TL_FLASH_EN)
module traffic_light_fsm #(
  parameter int YELLOW_CYCLES = 0,
  parameter int AGE_W = 8
`ifdef TL_FLASH_EN
  , parameter int FLASH_HALF = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change,
`ifdef TL_FLASH_EN
  input  logic             flash,
`endif
  output logic [1:0]       light,
  output logic [AGE_W-1:0] state_age
);
  typedef enum logic [1:0] {RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} state_t;
  localparam logic [31:0] YC_LAST = YELLOW_CYCLES - 1;
  state_t state, state_nx;
  logic [AGE_W-1:0] age_nx;
  logic [1:0] light_nx;
  logic expire;
  assign expire = (YELLOW_CYCLES > 0) && (state == YELLOW) && (32'(state_age) == YC_LAST);
`ifdef TL_FLASH_EN
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] F_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] F_HALF = FW'(FLASH_HALF);
  logic [FW-1:0] fcnt;
  // flash phase counter: runs only while flashing, cleared otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) fcnt <= '0;
    else fcnt <= flash ? ((fcnt == F_LAST) ? '0 : fcnt + 1'b1) : '0;
`endif
  // next phase, age and lamp code; any phase change clears the age
  always_comb begin
    state_nx = state;
    case (state)
      RED:     if (change) state_nx = GREEN;
      GREEN:   if (change) state_nx = YELLOW;
      YELLOW:  if (change || expire) state_nx = RED;
      default: state_nx = RED;
    endcase
    age_nx = (state_nx != state) ? '0 : ((&state_age) ? state_age : state_age + 1'b1);
    light_nx = state_nx;
`ifdef TL_FLASH_EN
    if (flash) begin
      state_nx = state;
      age_nx = state_age;
      light_nx = (fcnt < F_HALF) ? 2'b10 : 2'b11;
    end
`endif
  end
  // state, age and registered lamp code
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RED;
      state_age <= '0;
      light <= 2'b00;
    end else begin
      state <= state_nx;
      state_age <= age_nx;
      light <= light_nx;
    end
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: randomized + directed bench for traffic_light_fsm against a phase-list reference model
module tb_traffic_light_fsm;
  localparam int FH = 2;
  logic clk = 0, rst = 0, change = 0, flash = 0;
  logic [1:0] light0, light1;
  logic [3:0] age0;
  logic [7:0] age1;
  int errors = 0, checks = 0;
  int ph[2], age[2], fp[2], lt[2];
  int yc[2] = '{3, 0};
  int maxa[2] = '{15, 255};
  int seq_held[4] = '{1, 2, 0, 1};
  int seq_flash[6] = '{2, 2, 3, 3, 2, 2};

  always #5 clk = ~clk;

  traffic_light_fsm #(.YELLOW_CYCLES(3), .AGE_W(4)
`ifdef TL_FLASH_EN
    , .FLASH_HALF(FH)
`endif
  ) dut0 (.clk(clk), .rst(rst), .change(change),
`ifdef TL_FLASH_EN
    .flash(flash),
`endif
    .light(light0), .state_age(age0));

  traffic_light_fsm #(.YELLOW_CYCLES(0), .AGE_W(8)
`ifdef TL_FLASH_EN
    , .FLASH_HALF(FH)
`endif
  ) dut1 (.clk(clk), .rst(rst), .change(change),
`ifdef TL_FLASH_EN
    .flash(flash),
`endif
    .light(light1), .state_age(age1));

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // phase index 0/1/2 = RED/GREEN/YELLOW, which is also the lamp code
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; age[i] = 0; fp[i] = 0; lt[i] = 0;
    end
  endtask

  task automatic model_step();
    bit fl;
`ifdef TL_FLASH_EN
    fl = flash;
`else
    fl = 0;
`endif
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        lt[i] = (fp[i] < FH) ? 2 : 3;
        fp[i] = (fp[i] + 1) % (2 * FH);
      end else begin
        bit ex;
        fp[i] = 0;
        ex = yc[i] > 0 && ph[i] == 2 && age[i] == yc[i] - 1;
        if (change || ex) begin
          ph[i] = ex ? 0 : (ph[i] + 1) % 3;
          age[i] = 0;
        end else if (age[i] < maxa[i]) age[i]++;
        lt[i] = ph[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("light0", light0, lt[0]);
    check("age0", age0, age[0]);
    check("light1", light1, lt[1]);
    check("age1", age1, age[1]);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      change = ~change;
      tick();
      check("rst_light", light1, 0);
      check("rst_age", age1, 0);
    end
    change = 0; rst = 1;
    ticks(5);
    check("release_light", light1, 0);
    check("release_age", age1, 5);
    change = 1; tick(); change = 0;
    check("pulse_green", light1, 1);
    check("pulse_green_age", age1, 0);
    ticks(9);
    change = 1; tick(); change = 0;
    check("pulse_yellow", light1, 2);
    ticks(9);
    change = 1; tick(); change = 0;
    check("pulse_red", light1, 0);
    check("pulse_red_age", age1, 0);
    change = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held", light1, seq_held[i]);
    end
    change = 0;
    rst = 0; tick(); rst = 1;
    change = 1; ticks(2); change = 0;
    check("yel_enter0", light0, 2);
    tick(); check("yel_hold1", light0, 2);
    tick(); check("yel_hold2", light0, 2);
    tick(); check("yel_expire", light0, 0);
    ticks(97);
    check("yel_no_expire", light1, 2);
    check("yel_age100", age1, 100);
    change = 1; ticks(2); change = 0;
    check("pre_async", light1, 1);
    #2 rst = 0;
    model_reset();
    #1;
    check("async_light0", light0, 0);
    check("async_light1", light1, 0);
    check("async_age1", age1, 0);
    change = 1; ticks(2); change = 0;
    rst = 1;
    ticks(20);
    check("sat_age0", age0, 15);
    check("age1_20", age1, 20);
`ifdef TL_FLASH_EN
    change = 1; tick(); change = 0;
    ticks(2);
    flash = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) change = 1;
      tick();
      check("flash_seq", light1, seq_flash[i]);
      check("flash_age", age1, 2);
    end
    change = 0; flash = 0;
    tick();
    check("flash_exit_light", light1, 1);
    check("flash_exit_age", age1, 3);
`endif
    for (int i = 0; i < 400; i++) begin
      change = ($urandom_range(3) == 0);
      rst = ($urandom_range(49) != 0);
`ifdef TL_FLASH_EN
      if ($urandom_range(15) == 0) flash = ~flash;
`endif
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Single-approach traffic signal head: a 3-phase state machine (RED, GREEN, YELLOW) advanced by a one-cycle `change` strobe.
- Instantiated four times (N/E/S/W) under the intersection controller.
- The controller holds a head in reset to force RED and pulses `change` to sequence it.
- Provides an optional yellow auto-expiry and a cycle-age counter for the controller and debug.

Parameters:
- YELLOW_CYCLES, 0: cycles YELLOW holds before returning to RED on its own; 0 = no auto-expiry, YELLOW holds until the next `change`.
- AGE_W, 8: width of the `state_age` counter.
- FLASH_HALF, 4: half-period in cycles of the flash pattern (used only with TL_FLASH_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- change  in  1  advance strobe, sampled on the rising edge of clk
- light  out  2  lamp code: 00 RED, 01 GREEN, 10 YELLOW, 11 OFF
- state_age  out  AGE_W  cycles spent in the current phase; saturates

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RED, light=00, state_age=0, flash phase=0.
  - Held for as long as rst=0; `change` is ignored.
  - Release is synchronous: the first rising edge with rst=1 evaluates normally.
- Encoding: light is a registered output, decoded directly from state; no combinational path from `change` to `light`.
- Transitions, evaluated on each rising edge with rst=1:
  - RED + change=1 -> GREEN
  - GREEN + change=1 -> YELLOW
  - YELLOW + change=1 -> RED
  - change=0 -> hold, except YELLOW auto-expiry below.
- Latency: a change sampled at edge k gives the new light code immediately after edge k (one clock).
- Level `change`: if held high for N consecutive edges, the head advances N times (RED->GREEN->YELLOW->RED...). No edge detection.
- Yellow auto-expiry (YELLOW_CYCLES>0):
  - When state=YELLOW and state_age reaches YELLOW_CYCLES-1 with change=0, the next edge enters RED.
  - If change=1 on that same edge, the result is still RED (a single transition, not two).
- state_age:
  - Cleared to 0 on every state transition, including auto-expiry.
  - Otherwise increments by 1 per clock.
  - Saturates at 2^AGE_W-1; never wraps.
- Code 11 (OFF) is never produced outside flash mode.
- Reset asserted mid-phase (GREEN or YELLOW): light is 00 immediately and asynchronously, without waiting for a clock edge.
- Unused state encodings recover to RED on the next edge.

Optional Feature:
- Macro TL_FLASH_EN.
- When defined:
  - Adds input `flash` (1 bit).
  - While flash=1 and rst=1, the FSM state and state_age are frozen.
  - light alternates between YELLOW (10) and OFF (11), starting with YELLOW; each half-period lasts FLASH_HALF cycles, driven by an internal counter.
  - `change` is ignored while flashing.
  - When flash returns to 0, light shows the frozen state on the next edge and the flash counter clears.
  - Reset overrides flash.
- When undefined: no `flash` port, no flash counter, and code 11 is unreachable.

Test Plan:
- Reset: rst=0 with change toggling -> light=00, state_age=0 throughout; release rst, idle 5 cycles -> light=00, state_age=5.
- Sequencing: one-cycle change pulses at cycles 2, 12, 22 -> light 00 -> 01 at cycle 3 -> 10 at cycle 13 -> 00 at cycle 23; state_age=0 after each transition.
- Held change for 4 edges from RED -> light sequence 01, 10, 00, 01.
- YELLOW_CYCLES=3: enter YELLOW, change=0 -> RED exactly 3 cycles later; with YELLOW_CYCLES=0, YELLOW holds 100 cycles.
- Async reset in GREEN mid-cycle -> light=00 before the next edge; state_age saturation with AGE_W=4 -> holds at 15 after 20 idle cycles.
- TL_FLASH_EN, FLASH_HALF=2, flash=1 in GREEN -> light 10,10,11,11,10...; flash=0 -> light=01 and state_age resumes from its frozen value.
